// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding and the
// idle levels the transmitter lines rest at.
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic SDO_IDLE  = 1'b0;
    localparam logic PEN_IDLE  = 1'b1;
    localparam logic CLR_IDLE  = 1'b1;

endpackage

// File: rtl/serial_frame_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with rise/fall strobes
// taken between the last synchroniser stage and one extra registered copy.
module serial_frame_rx_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic IDLE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {STAGES{IDLE}};
            prev <= IDLE;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/serial_frame_rx.sv
// Deserialises one {sclk, sdo, pen, clr} frame into a parallel word, flagging
// short, overrun and stalled frames with a one-cycle frame_err pulse.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int INVERT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             sdo,
    input  logic             pen,
    input  logic             clr,
    output logic [WIDTH-1:0] pdata,
    output logic             valid,
    output logic             frame_err,
    output logic             busy,
    output logic [6:0]       bit_cnt
);

    localparam int             TW       = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [6:0]     CNT_MAX  = 7'(WIDTH + 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;
    logic sdo_s, sdo_rise_unused, sdo_fall_unused;
    logic pen_s, pen_rise, pen_fall_unused;
    logic clr_s, clr_rise_unused, clr_fall_unused;

    serial_frame_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(SCLK_IDLE)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );
    serial_frame_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(SDO_IDLE)) u_sync_sdo (
        .clk(clk), .rst(rst), .d(sdo),
        .q(sdo_s), .rise(sdo_rise_unused), .fall(sdo_fall_unused)
    );
    serial_frame_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(PEN_IDLE)) u_sync_pen (
        .clk(clk), .rst(rst), .d(pen),
        .q(pen_s), .rise(pen_rise), .fall(pen_fall_unused)
    );
    serial_frame_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(CLR_IDLE)) u_sync_clr (
        .clk(clk), .rst(rst), .d(clr),
        .q(clr_s), .rise(clr_rise_unused), .fall(clr_fall_unused)
    );

    state_t            state;
    logic [WIDTH-1:0]  shift_reg;
    logic [TW-1:0]     tmo_cnt;
    logic              shift_en;
    logic [WIDTH-1:0]  shifted;
    logic [6:0]        cnt_inc;

    // A bit arriving in the same sample as the pen rise still belongs to the frame.
    assign shift_en = sclk_rise && (!pen_s || pen_rise);
    assign shifted  = {shift_reg[WIDTH-2:0], sdo_s};
    assign cnt_inc  = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 7'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            pdata     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (!clr_s) begin
                state     <= IDLE;
                shift_reg <= '0;
                pdata     <= '0;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                tmo_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tmo_cnt <= '0;
                        if (sclk_rise && !pen_s) begin
                            shift_reg <= shifted;
                            bit_cnt   <= cnt_inc;
                            busy      <= 1'b1;
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (shift_en) begin
                            shift_reg <= shifted;
                            bit_cnt   <= cnt_inc;
                        end
                        if (pen_rise) begin
                            busy    <= 1'b0;
                            tmo_cnt <= '0;
                            state   <= LATCH;
                        end else if (sclk_rise) begin
                            tmo_cnt <= '0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            frame_err <= 1'b1;
                            bit_cnt   <= '0;
                            busy      <= 1'b0;
                            tmo_cnt   <= '0;
                            state     <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    LATCH: begin
                        if (bit_cnt == 7'(WIDTH)) begin
                            pdata <= (INVERT != 0) ? ~shift_reg : shift_reg;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a normal and an inverting receiver share the
// same serial lines; expectations come from a bit-queue model of the frame.
module tb_serial_frame_rx;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, sclk, sdo, pen, clr;
  logic [W-1:0] pdata, pdata_inv;
  logic valid, frame_err, busy, valid_inv, frame_err_inv, busy_inv;
  logic [6:0] bit_cnt, bit_cnt_inv;

  int n_tests = 0;
  int n_fail = 0;
  int v_cnt = 0, e_cnt = 0, both_cnt = 0;

  bit rx_bits[$];
  logic [W-1:0] exp_pdata = '0;
  logic [W-1:0] exp_q[$];

  serial_frame_rx #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(1024), .INVERT(0)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdo(sdo), .pen(pen), .clr(clr),
    .pdata(pdata), .valid(valid), .frame_err(frame_err), .busy(busy), .bit_cnt(bit_cnt)
  );

  serial_frame_rx #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(1024), .INVERT(1)) dut_inv (
    .clk(clk), .rst(rst), .sclk(sclk), .sdo(sdo), .pen(pen), .clr(clr),
    .pdata(pdata_inv), .valid(valid_inv), .frame_err(frame_err_inv), .busy(busy_inv),
    .bit_cnt(bit_cnt_inv)
  );

  // clock / reset
  always #5 clk = ~clk;

  // pulse monitor, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) v_cnt++;
    if (frame_err === 1'b1) e_cnt++;
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (valid_inv === 1'b1 && frame_err_inv === 1'b1) both_cnt++;
  end

  // model: first bit of the frame lands in the MSB
  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) w[W-1-i] = rx_bits[i];
    return w;
  endfunction

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    sdo = b;
    wait_clk(4);
    sclk = 1'b1;
    if (pen == 1'b0) rx_bits.push_back(b);
    wait_clk(8);
    sclk = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      if (i < W) b = w[W-1-i];
      else b = 1'($urandom_range(0, 1));
      send_bit(b);
    end
  endtask

  task automatic begin_frame();
    pen = 1'b0;
    wait_clk(4);
  endtask

  // raises pen (optionally together with a final sclk rise) and measures valid latency
  task automatic latch_frame(input bit with_bit, input bit last_b, output int lat, output bit good);
    if (with_bit) begin
      sdo = last_b;
      wait_clk(4);
      rx_bits.push_back(last_b);
      sclk = 1'b1;
    end
    good = (rx_bits.size() == W);
    if (good) begin
      exp_pdata = pack_bits();
      exp_q.push_back(exp_pdata);
    end
    rx_bits.delete();
    pen = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid === 1'b1 && lat < 0) lat = k;
      if (k == 8) sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; sdo = 1'b0; pen = 1'b1; clr = 1'b1;
    wait_clk(3);
    n_tests++; if (pdata !== '0) begin n_fail++; $display("FAIL reset_pdata got=%h exp=0", pdata); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (bit_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_invert();
    int lat, v0;
    bit good;
    logic [W-1:0] exp;
    v0 = v_cnt;
    begin_frame();
    send_word(16'h00FF, W);
    latch_frame(1'b0, 1'b0, lat, good);
    exp = exp_q.pop_front();
    n_tests++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL invert_valid got=%0d exp=1", v_cnt - v0); end
    n_tests++; if (pdata_inv !== ~exp) begin n_fail++; $display("FAIL invert_pdata got=%h exp=%h", pdata_inv, ~exp); end
    n_tests++; if (pdata !== exp) begin n_fail++; $display("FAIL invert_plain got=%h exp=%h", pdata, exp); end
  endtask

  task automatic test_good_frame();
    int lat, v0, e0;
    bit good;
    logic [W-1:0] exp;
    v0 = v_cnt; e0 = e_cnt;
    begin_frame();
    send_word(16'hA5C3, W);
    latch_frame(1'b0, 1'b0, lat, good);
    exp = exp_q.pop_front();
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL good_latency got=%0d exp=4", lat); end
    n_tests++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL good_valid got=%0d exp=1", v_cnt - v0); end
    n_tests++; if (e_cnt - e0 !== 0) begin n_fail++; $display("FAIL good_err got=%0d exp=0", e_cnt - e0); end
    n_tests++; if (pdata !== exp) begin n_fail++; $display("FAIL good_pdata got=%h exp=%h", pdata, exp); end
    n_tests++; if (bit_cnt !== 7'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL good_idle got=%0d/%b exp=0/0", bit_cnt, busy); end
  endtask

  task automatic test_simultaneous();
    int lat, v0;
    bit good;
    logic [W-1:0] exp;
    v0 = v_cnt;
    begin_frame();
    send_word(16'h5A3C, W - 1);
    latch_frame(1'b1, 1'b0, lat, good);
    exp = exp_q.pop_front();
    n_tests++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL simul_valid got=%0d exp=1", v_cnt - v0); end
    n_tests++; if (pdata !== exp) begin n_fail++; $display("FAIL simul_pdata got=%h exp=%h", pdata, exp); end
  endtask

  task automatic test_short();
    int lat, v0, e0;
    bit good;
    v0 = v_cnt; e0 = e_cnt;
    begin_frame();
    send_word(16'h0F0F, W - 1);
    latch_frame(1'b0, 1'b0, lat, good);
    n_tests++; if (e_cnt - e0 !== 1) begin n_fail++; $display("FAIL short_err got=%0d exp=1", e_cnt - e0); end
    n_tests++; if (v_cnt - v0 !== 0) begin n_fail++; $display("FAIL short_valid got=%0d exp=0", v_cnt - v0); end
    n_tests++; if (pdata !== exp_pdata) begin n_fail++; $display("FAIL short_pdata got=%h exp=%h", pdata, exp_pdata); end
  endtask

  task automatic test_overrun();
    int lat, v0, e0, exp_cnt;
    bit good;
    v0 = v_cnt; e0 = e_cnt;
    begin_frame();
    send_word(16'hC0DE, W + 2);
    exp_cnt = (rx_bits.size() > W + 1) ? W + 1 : rx_bits.size();
    n_tests++; if (bit_cnt !== 7'(exp_cnt)) begin n_fail++; $display("FAIL over_bit_cnt got=%0d exp=%0d", bit_cnt, exp_cnt); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL over_busy got=%b exp=1", busy); end
    latch_frame(1'b0, 1'b0, lat, good);
    n_tests++; if (e_cnt - e0 !== 1 || v_cnt - v0 !== 0) begin n_fail++; $display("FAIL over_pulses got=%0d/%0d exp=1/0", e_cnt - e0, v_cnt - v0); end
    n_tests++; if (pdata !== exp_pdata) begin n_fail++; $display("FAIL over_pdata got=%h exp=%h", pdata, exp_pdata); end
  endtask

  task automatic test_timeout();
    int lat, v0, e0;
    bit good;
    logic [W-1:0] exp;
    begin_frame();
    send_word(16'hF800, 5);
    e0 = e_cnt;
    wait_clk(990);
    n_tests++; if (e_cnt - e0 !== 0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early got=%0d/%b exp=0/1", e_cnt - e0, busy); end
    wait_clk(60);
    rx_bits.delete();
    n_tests++; if (e_cnt - e0 !== 1) begin n_fail++; $display("FAIL tmo_err got=%0d exp=1", e_cnt - e0); end
    n_tests++; if (busy !== 1'b0 || bit_cnt !== 7'd0) begin n_fail++; $display("FAIL tmo_idle got=%b/%0d exp=0/0", busy, bit_cnt); end
    n_tests++; if (pdata !== exp_pdata) begin n_fail++; $display("FAIL tmo_pdata got=%h exp=%h", pdata, exp_pdata); end
    v0 = v_cnt;
    send_word(16'h1234, W);
    latch_frame(1'b0, 1'b0, lat, good);
    exp = exp_q.pop_front();
    n_tests++; if (v_cnt - v0 !== 1 || pdata !== exp) begin n_fail++; $display("FAIL tmo_next got=%0d/%h exp=1/%h", v_cnt - v0, pdata, exp); end
  endtask

  task automatic test_clear_and_reset();
    int lat, v0, e0;
    bit good;
    logic [W-1:0] exp;
    begin_frame();
    send_word(16'hBEEF, W);
    latch_frame(1'b0, 1'b0, lat, good);
    exp = exp_q.pop_front();
    n_tests++; if (pdata !== exp) begin n_fail++; $display("FAIL clr_pre_pdata got=%h exp=%h", pdata, exp); end
    v0 = v_cnt; e0 = e_cnt;
    clr = 1'b0;
    wait_clk(4);
    clr = 1'b1;
    wait_clk(4);
    exp_pdata = '0;
    rx_bits.delete();
    n_tests++; if (pdata !== exp_pdata) begin n_fail++; $display("FAIL clr_pdata got=%h exp=%h", pdata, exp_pdata); end
    n_tests++; if (v_cnt - v0 !== 0 || e_cnt - e0 !== 0) begin n_fail++; $display("FAIL clr_pulses got=%0d/%0d exp=0/0", v_cnt - v0, e_cnt - e0); end
    begin_frame();
    send_word(16'h8181, 8);
    n_tests++; if (bit_cnt !== 7'(rx_bits.size()) || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre got=%0d/%b exp=%0d/1", bit_cnt, busy, rx_bits.size()); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bit_cnt !== 7'd0 || busy !== 1'b0 || pdata !== '0) begin n_fail++; $display("FAIL rst_mid got=%0d/%b/%h exp=0/0/0", bit_cnt, busy, pdata); end
    @(negedge clk);
    pen = 1'b1;
    rx_bits.delete();
    exp_pdata = '0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_random();
    int lat, v0, e0, nbits, sel;
    bit good;
    logic [W-1:0] w, exp;
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int s = 0; s < int'($urandom_range(1, 2)); s++) send_bit(1'($urandom_range(0, 1)));
      end
      sel = $urandom_range(0, 3);
      if (sel < 2) nbits = W;
      else if (sel == 2) nbits = $urandom_range(1, W - 1);
      else nbits = $urandom_range(W + 1, W + 3);
      w = W'($urandom);
      v0 = v_cnt; e0 = e_cnt;
      begin_frame();
      send_word(w, nbits);
      latch_frame(1'b0, 1'b0, lat, good);
      if (good) begin
        exp = exp_q.pop_front();
        n_tests++; if (v_cnt - v0 !== 1 || e_cnt - e0 !== 0) begin n_fail++; $display("FAIL rnd_good_pulses f=%0d got=%0d/%0d exp=1/0", f, v_cnt - v0, e_cnt - e0); end
        n_tests++; if (pdata !== exp || pdata_inv !== ~exp) begin n_fail++; $display("FAIL rnd_pdata f=%0d got=%h/%h exp=%h/%h", f, pdata, pdata_inv, exp, ~exp); end
      end else begin
        n_tests++; if (v_cnt - v0 !== 0 || e_cnt - e0 !== 1) begin n_fail++; $display("FAIL rnd_bad_pulses f=%0d got=%0d/%0d exp=0/1", f, v_cnt - v0, e_cnt - e0); end
        n_tests++; if (pdata !== exp_pdata) begin n_fail++; $display("FAIL rnd_keep f=%0d got=%h exp=%h", f, pdata, exp_pdata); end
      end
    end
    n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_and_err_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_invert();
    test_good_frame();
    test_simultaneous();
    test_short();
    test_overrun();
    test_timeout();
    test_clear_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
